instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter addresswidth, default 10, the word-index width of the instruction memory port.
REQ-002 The block SHALL have parameter width, default 32, the instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, a reset that is asynchronous and active-low.
REQ-006 The block SHALL have port instrAddr, output, addresswidth, the word index driven to the instruction memory.
REQ-007 The block SHALL have port instrData, input, width, the memory read data, equal to mem[instrAddr sampled at the previous edge].
REQ-008 The block SHALL have port redirect_valid, input, 1, a branch/jump redirect request.
REQ-009 The block SHALL have port redirect_target, input, 32, the byte address of the redirect.
REQ-010 The block SHALL have port instr_valid, output, 1, meaning instr/instr_pc are valid.
REQ-011 The block SHALL have port instr_ready, input, 1, the downstream accept signal.
REQ-012 The block SHALL have port instr, output, width, the fetched instruction.
REQ-013 The block SHALL have port instr_pc, output, 32, the byte address of instr.

Function
REQ-014 The block SHALL hold a 32-bit fetch_pc; instrAddr SHALL equal addr[addresswidth+1:2], where addr is redirect_target when redirect_valid=1 and fetch_pc otherwise.
REQ-015 The block SHALL issue a request at an edge when redirect_valid=1, or when the skid entry is empty and the in-flight response will not need skid capture (no inflight, or fire).
REQ-016 An issued request SHALL set inflight_valid=1 and inflight_pc=addr, and SHALL set fetch_pc=addr+4 with 32-bit modulo wrap (32'hFFFF_FFFC -> 0).
REQ-017 A cycle with no issue and no redirect SHALL clear inflight_valid (after any capture) and SHALL leave fetch_pc unchanged.
REQ-018 Output selection SHALL be the skid entry when skid_valid=1, otherwise instrData/inflight_pc with instr_valid=inflight_valid.
REQ-019 instr_valid SHALL be forced to 0 in any cycle with redirect_valid=1.
REQ-020 A handshake fire SHALL occur when instr_valid=1 and instr_ready=1; each fetched instruction SHALL fire exactly once, in PC order.
REQ-021 When inflight_valid=1, skid_valid=0 and instr_ready=0, the block SHALL capture instrData/inflight_pc into the skid entry at the edge.
REQ-022 A fire from the skid entry SHALL clear skid_valid.
REQ-023 Instruction and PC SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-024 With instr_ready held at 1 and no redirect, throughput SHALL be one instruction per cycle, with a fetch-to-instr latency of 1 cycle.
REQ-025 A redirect at edge N SHALL flush the skid entry and the old inflight, issue redirect_target[31:2]<<2 (low bits forced to 00), and present the target instruction in cycle N+1.
REQ-026 Simultaneous redirect and stall (instr_ready=0) SHALL give redirect priority.
REQ-027 Memory index wrap SHALL be implicit: PC bits above addresswidth+1 SHALL be ignored for instrAddr, but kept in instr_pc.

Reset
REQ-028 While reset_n=0, the block SHALL set fetch_pc=RESET_PC, inflight_valid=0, skid_valid=0, instr_valid=0, instr_pc=0 and instr=0, and instrAddr SHALL equal RESET_PC[addresswidth+1:2].
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered instructions immediately (asynchronously).
REQ-030 After deassertion, the first request (RESET_PC) SHALL issue at the first edge, with instr_valid=1 in the following cycle.

Structure
REQ-031 The shared package fetch_pkg SHALL hold PC_W=32, INSTR_W=32, RESET_PC_DEFAULT and the byte-to-word shift constant 2.
REQ-032 The one-entry holding register SHALL be the sub-module fetch_skid_buffer (ports load, data/pc in, clear, valid/data/pc out).
REQ-033 The block SHALL contain no combinational path from instr_ready to instrAddr other than through the issue decision.

Verification
REQ-034 The bench SHALL apply reset, with mem[i]=i*16, and instr_ready=1 -> instr_pc 0,4,8,C with instr 0,16,32,48 on consecutive cycles, first valid one cycle after reset release.
REQ-035 The bench SHALL deassert instr_ready for 3 cycles while instr_pc=8 is presented -> pc 8 held stable, then 8,C,10 issued with no loss or duplication.
REQ-036 The bench SHALL apply redirect_valid=1 with target 32'h40 while pc 0x10 is pending -> instr_valid=0 that cycle, next valid pc=0x40 with instr=mem[16], and no 0x10/0x14 output.
REQ-037 The bench SHALL apply a redirect with instr_ready=0 and a full skid, target 32'h23 -> skid flushed, instr_pc=0x20.
REQ-038 The bench SHALL use RESET_PC=32'hFFFF_FFF8 -> pcs FFFFFFF8, FFFFFFFC, 0, 4 with instrAddr wrapping correctly.
REQ-039 The bench SHALL assert reset_n low mid-stream between edges -> instr_valid=0 immediately, and fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset address and byte/word helpers for the fetch stage
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam int BYTE_SHIFT = 2;
  typedef logic [PC_W-1:0] pc_t;
  localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic pc_t word_align(input pc_t a);
    return a & ~((pc_t'(1) << BYTE_SHIFT) - pc_t'(1));
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory port, redirect request and instruction handshake of the fetch stage
// master (fetch unit): drives instrAddr, instr_valid, instr, instr_pc; reads instrData, redirect_*, instr_ready
// slave (environment): the mirror image
interface instruction_fetch_if #(
  parameter int addresswidth = 10,
  parameter int width = 32
);
  import fetch_pkg::*;
  logic [addresswidth-1:0] instrAddr;
  logic [width-1:0] instrData;
  logic redirect_valid;
  pc_t redirect_target;
  logic instr_valid;
  logic instr_ready;
  logic [width-1:0] instr;
  pc_t instr_pc;
  modport master(
    output instrAddr, instr_valid, instr, instr_pc,
    input instrData, redirect_valid, redirect_target, instr_ready
  );
  modport slave(
    input instrAddr, instr_valid, instr, instr_pc,
    output instrData, redirect_valid, redirect_target, instr_ready
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a response that arrived while downstream stalled
// load/data_in/pc_in capture an entry, clear empties it (clear wins), valid/data/pc present it
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int width = INSTR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [width-1:0] data_in,
  input  pc_t              pc_in,
  input  logic             clear,
  output logic             valid,
  output logic [width-1:0] data,
  output pc_t              pc
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data <= '0;
      pc <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data <= data_in;
      pc <= pc_in;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential fetch with redirect, one-cycle memory latency and a skid entry for stalls
// clk/reset_n: clock and async active-low reset
// bus.instrAddr/instrData: synchronous instruction memory (data = mem[addr of previous edge])
// bus.redirect_valid/redirect_target: branch/jump redirect, byte address
// bus.instr_valid/instr_ready/instr/instr_pc: fetched instruction handshake
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int  addresswidth = 10,
  parameter int  width = INSTR_W,
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  instruction_fetch_if.master bus
);
  pc_t fetch_pc, inflight_pc, addr, skid_pc;
  logic inflight_valid, skid_valid, fire, issue, capture, skid_clear;
  logic [width-1:0] skid_data;
  // Address depends only on redirect and fetch_pc, never on instr_ready.
  assign addr = bus.redirect_valid ? word_align(bus.redirect_target) : fetch_pc;
  assign bus.instrAddr = addr[addresswidth+1:BYTE_SHIFT];
  assign bus.instr_valid = !bus.redirect_valid && (skid_valid || inflight_valid);
  assign bus.instr = skid_valid ? skid_data : inflight_valid ? bus.instrData : '0;
  assign bus.instr_pc = skid_valid ? skid_pc : inflight_valid ? inflight_pc : '0;
  assign fire = bus.instr_valid && bus.instr_ready;
  // Only issue when the response now in flight is guaranteed a home: consumed this cycle or nothing pending.
  assign issue = bus.redirect_valid || (!skid_valid && (!inflight_valid || fire));
  assign capture = !bus.redirect_valid && inflight_valid && !skid_valid && !bus.instr_ready;
  assign skid_clear = bus.redirect_valid || (skid_valid && fire);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= addr;
        fetch_pc <= addr + pc_t'(4);
      end
    end
  end
  fetch_skid_buffer #(.width(width)) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .load(capture),
    .data_in(bus.instrData),
    .pc_in(inflight_pc),
    .clear(skid_clear),
    .valid(skid_valid),
    .data(skid_data),
    .pc(skid_pc)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a PC-sequence model
module tb_instruction_fetch;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_n2 = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic o_valid;
  pc_t o_pc;
  logic [31:0] o_instr;
  logic [9:0] o_addr;
  instruction_fetch_if #(.addresswidth(10), .width(32)) bus1 ();
  instruction_fetch_if #(.addresswidth(10), .width(32)) bus2 ();
  instruction_fetch #(.addresswidth(10), .width(32), .RESET_PC(32'h0000_0000)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );
  instruction_fetch #(.addresswidth(10), .width(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset_n(reset_n2), .bus(bus2)
  );
  always #5 clk = ~clk;
  // Memory contents: mem[i] = i*16, one-cycle read latency.
  always @(posedge clk) begin
    bus1.instrData <= 32'(bus1.instrAddr) << 4;
    bus2.instrData <= 32'(bus2.instrAddr) << 4;
  end
  function automatic logic [31:0] mem_word(input pc_t pc);
    return 32'(pc[11:2]) << 4;
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic cycle(input logic rv, input pc_t rt, input logic rdy);
    bus1.redirect_valid = rv;
    bus1.redirect_target = rt;
    bus1.instr_ready = rdy;
    #1;
    o_valid = bus1.instr_valid;
    o_pc = bus1.instr_pc;
    o_instr = bus1.instr;
    o_addr = bus1.instrAddr;
    tick();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.instr_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    cycle(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
    n_checks++;
    if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    n_checks++;
    if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_instr); end
    n_checks++;
    if (o_addr !== 10'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", o_addr); end
  endtask
  task automatic test_stream();
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first: valid=%0b before first edge, want 0", o_valid); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== pc_t'(4 * i) || o_instr !== 32'(16 * i)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", i, o_valid, o_pc, o_instr, 4 * i, 16 * i);
      end
    end
  endtask
  task automatic test_stall();
    pc_t fired[$];
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== 32'd32) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h instr=%h want v=1 pc=8 instr=20", i, o_valid, o_pc, o_instr);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) begin
        fired.push_back(o_pc);
        n_checks++;
        if (o_instr !== mem_word(o_pc)) begin n_fail++; $display("FAIL stall_data: pc=%h got %h want %h", o_pc, o_instr, mem_word(o_pc)); end
      end
    end
    n_checks++;
    if (fired.size() < 3 || fired[0] !== 32'h8 || fired[1] !== 32'hC || fired[2] !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_order: got %0d fires first=%h,%h,%h want 8,c,10", fired.size(),
               fired.size() > 0 ? fired[0] : 32'hx, fired.size() > 1 ? fired[1] : 32'hx, fired.size() > 2 ? fired[2] : 32'hx);
    end
  endtask
  task automatic test_redirect();
    do_reset();
    repeat (5) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h40, 1'b1);
    n_checks++;
    if (o_valid !== 1'b0 || o_addr !== 10'd16) begin
      n_fail++;
      $display("FAIL redirect_cycle: got v=%0b addr=%h want v=0 addr=10", o_valid, o_addr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== pc_t'(32'h40 + 4 * i) || o_instr !== mem_word(pc_t'(32'h40 + 4 * i))) begin
        n_fail++;
        $display("FAIL redirect_seq[%0d]: got v=%0b pc=%h instr=%h want pc=%h", i, o_valid, o_pc, o_instr, 32'h40 + 4 * i);
      end
    end
  endtask
  task automatic test_redirect_stall();
    pc_t fired[$];
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h23, 1'b0);
    n_checks++;
    if (o_valid !== 1'b0 || o_addr !== 10'd8) begin
      n_fail++;
      $display("FAIL rstall_cycle: got v=%0b addr=%h want v=0 addr=8", o_valid, o_addr);
    end
    cycle(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_instr !== 32'd128) begin
      n_fail++;
      $display("FAIL rstall_target: got v=%0b pc=%h instr=%h want v=1 pc=20 instr=80", o_valid, o_pc, o_instr);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) fired.push_back(o_pc);
    end
    n_checks++;
    if (fired.size() < 2 || fired[0] !== 32'h20 || fired[1] !== 32'h24) begin
      n_fail++;
      $display("FAIL rstall_order: got %0d fires first=%h,%h want 20,24", fired.size(),
               fired.size() > 0 ? fired[0] : 32'hx, fired.size() > 1 ? fired[1] : 32'hx);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    bus1.instr_ready = 1'b1;
    #1;
    n_checks++;
    if (bus1.instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got v=%0b want 1", bus1.instr_valid); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.instr_valid !== 1'b0 || bus1.instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async: got v=%0b pc=%h want v=0 pc=0", bus1.instr_valid, bus1.instr_pc);
    end
    tick();
    tick();
    reset_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release: got v=%0b want 0", o_valid); end
    cycle(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_resume: got v=%0b pc=%h instr=%h want v=1 pc=0 instr=0", o_valid, o_pc, o_instr);
    end
  endtask
  task automatic test_wrap();
    pc_t e;
    #1;
    n_checks++;
    if (bus2.instrAddr !== 10'h3FE || bus2.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset: got addr=%h v=%0b want addr=3fe v=0", bus2.instrAddr, bus2.instr_valid);
    end
    tick();
    reset_n2 = 1'b1;
    #1;
    n_checks++;
    if (bus2.instr_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_first: got v=%0b want 0", bus2.instr_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      e = 32'hFFFF_FFF8 + pc_t'(4 * i);
      #1;
      n_checks++;
      if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== e || bus2.instr !== mem_word(e) || bus2.instrAddr !== 10'(e[11:2] + 10'd1)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got v=%0b pc=%h instr=%h addr=%h want pc=%h instr=%h addr=%h", i, bus2.instr_valid,
                 bus2.instr_pc, bus2.instr, bus2.instrAddr, e, mem_word(e), 10'(e[11:2] + 10'd1));
      end
      tick();
    end
  endtask
  task automatic test_random();
    pc_t exp_pc, ppc, rt;
    logic [31:0] pinstr;
    logic pv, prdy, prv, rv, rdy;
    int idle;
    do_reset();
    exp_pc = 32'h0;
    pv = 1'b0;
    prdy = 1'b1;
    prv = 1'b0;
    ppc = '0;
    pinstr = '0;
    idle = 0;
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 9) == 0);
      rt = $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      cycle(rv, rt, rdy);
      if (rv) begin
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect_valid[%0d]: got %0b want 0", n, o_valid); end
        exp_pc = rt & ~32'h3;
        idle = 0;
      end else begin
        if (pv && !prdy && !prv) begin
          n_checks++;
          if (o_valid !== 1'b1 || o_pc !== ppc || o_instr !== pinstr) begin
            n_fail++;
            $display("FAIL rnd_stable[%0d]: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", n, o_valid, o_pc, o_instr, ppc, pinstr);
          end
        end
        if (o_valid && rdy) begin
          n_checks++;
          if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
            n_fail++;
            $display("FAIL rnd_fire[%0d]: got pc=%h instr=%h want pc=%h instr=%h", n, o_pc, o_instr, exp_pc, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
        end
        idle = o_valid ? 0 : idle + 1;
        n_checks++;
        if (idle > 1) begin n_fail++; $display("FAIL rnd_stallout[%0d]: got %0d idle cycles want <=1", n, idle); end
      end
      pv = o_valid;
      prdy = rdy;
      prv = rv;
      ppc = o_pc;
      pinstr = o_instr;
    end
  endtask
  initial begin
    bus1.redirect_valid = 1'b0;
    bus1.redirect_target = '0;
    bus1.instr_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_target = '0;
    bus2.instr_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
